// File: rtl/regfile_wr_arbiter.sv
// Write-back arbiter for a 2-write-port register file: grants up to two
// requesters per cycle round-robin, drops address-0 writes, registers port outputs.
module regfile_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic                             o_we_a,
  output logic [ADDR_WIDTH-1:0]            o_addr_wr_a,
  output logic [DATA_WIDTH-1:0]            o_data_in_a,
  output logic                             o_we_b,
  output logic [ADDR_WIDTH-1:0]            o_addr_wr_b,
  output logic [DATA_WIDTH-1:0]            o_data_in_b,
  output logic [15:0]                      o_drop_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
  logic [NUM_REQ-1:0]    w_zero;
  logic [NUM_REQ-1:0]    w_nz;
  logic [IDX_W:0]        w_zero_cnt;
  logic [16:0]           w_drop_sum;
  logic [15:0]           w_drop_next;

  logic                  w_a_found;
  logic                  w_b_found;
  logic [IDX_W-1:0]      w_a_idx;
  logic [IDX_W-1:0]      w_b_idx;
  logic [IDX_W-1:0]      w_scan_idx;
  logic [NUM_REQ-1:0]    w_ready;

  logic                  r_we_a;
  logic [ADDR_WIDTH-1:0] r_addr_wr_a;
  logic [DATA_WIDTH-1:0] r_data_in_a;
  logic                  r_we_b;
  logic [ADDR_WIDTH-1:0] r_addr_wr_b;
  logic [DATA_WIDTH-1:0] r_data_in_b;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [15:0]           r_drop_cnt;

  always_comb begin
    w_zero_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addr[i]  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_data[i]  = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      w_zero[i]  = i_req_valid[i] && (w_addr[i] == '0);
      w_nz[i]    = i_req_valid[i] && (w_addr[i] != '0);
      w_zero_cnt = w_zero_cnt + {{IDX_W{1'b0}}, w_zero[i]};
    end
  end

  // Scan from the round-robin pointer; the B winner must target a different
  // register than A, otherwise port A priority in the file would lose a write.
  always_comb begin
    w_a_found  = 1'b0;
    w_b_found  = 1'b0;
    w_a_idx    = '0;
    w_b_idx    = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = r_rr_ptr + IDX_W'(k);
      if (w_nz[w_scan_idx]) begin
        if (!w_a_found) begin
          w_a_found = 1'b1;
          w_a_idx   = w_scan_idx;
        end else if (!w_b_found && (w_addr[w_scan_idx] != w_addr[w_a_idx])) begin
          w_b_found = 1'b1;
          w_b_idx   = w_scan_idx;
        end
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (i_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_ready[i] = w_zero[i]
                   || (w_a_found && (w_a_idx == IDX_W'(i)))
                   || (w_b_found && (w_b_idx == IDX_W'(i)));
      end
    end
  end

  always_comb begin
    w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_zero_cnt);
    w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we_a      <= 1'b0;
      r_addr_wr_a <= '0;
      r_data_in_a <= '0;
      r_we_b      <= 1'b0;
      r_addr_wr_b <= '0;
      r_data_in_b <= '0;
      r_rr_ptr    <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_we_a     <= w_a_found;
      r_we_b     <= w_b_found;
      r_drop_cnt <= w_drop_next;
      if (w_a_found) begin
        r_addr_wr_a <= w_addr[w_a_idx];
        r_data_in_a <= w_data[w_a_idx];
      end
      if (w_b_found) begin
        r_addr_wr_b <= w_addr[w_b_idx];
        r_data_in_b <= w_data[w_b_idx];
      end
      if (w_b_found)
        r_rr_ptr <= w_b_idx + 1'b1;
      else if (w_a_found)
        r_rr_ptr <= w_a_idx + 1'b1;
    end
  end

  assign o_req_ready = w_ready;
  assign o_we_a      = r_we_a;
  assign o_addr_wr_a = r_addr_wr_a;
  assign o_data_in_a = r_data_in_a;
  assign o_we_b      = r_we_b;
  assign o_addr_wr_b = r_addr_wr_b;
  assign o_data_in_b = r_data_in_b;
  assign o_drop_cnt  = r_drop_cnt;

endmodule
